// File: rtl/npu_result_packer_if.sv
// ---------------------------------------------------------------------------
// npu_result_packer_if
// Groups the two streams around the result packer:
//   acc_*  : accumulator results from the compute array (valid/ready/last)
//   out_*  : packed 32-bit words toward the DMA data_from_npu port
// Modports:
//   master : the packer side (consumes acc_*, produces out_*)
//   slave  : the environment side (producer of acc_*, consumer of out_*)
// ---------------------------------------------------------------------------
interface npu_result_packer_if #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 32
);
  logic [ACC_W-1:0] acc_data;
  logic             acc_valid;
  logic             acc_last;
  logic             acc_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    input  acc_data, acc_valid, acc_last, out_ready,
    output acc_ready, out_data, out_valid
  );

  modport slave (
    output acc_data, acc_valid, acc_last, out_ready,
    input  acc_ready, out_data, out_valid
  );
endinterface

// File: rtl/npu_result_packer.sv
// ---------------------------------------------------------------------------
// npu_result_packer
// Requantizes signed accumulator results to int8 (rounded arithmetic shift,
// optional ReLU, saturation), packs LANES bytes little-endian per output word
// and drives the DMA write stream. A partial word is flushed on acc_last.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           one-cycle pulse: clears the packer, latches cfg_*
//   cfg_shift       right-shift amount 0..31
//   cfg_relu        ReLU enable
//   bus (master)    acc_* input stream, out_* packed output stream
//   out_words       words handshaken on the output since start (wraps)
//   busy            tile in progress
//   done            one-cycle pulse after the last word is accepted
// ---------------------------------------------------------------------------
module npu_result_packer #(
  parameter int ACC_W = 32,
  parameter int LANES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4:0]          cfg_shift,
  input  logic                cfg_relu,
  npu_result_packer_if.master bus,
  output logic [31:0]         out_words,
  output logic                busy,
  output logic                done
);

  localparam int OUT_W = 8 * LANES;
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ACC_W:0]   RND_ONE   = {{ACC_W{1'b0}}, 1'b1};
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-6){1'b0}}, 7'h7F};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-6){1'b1}}, 7'h00};

  // Requantize one accumulator value to int8. One extra bit of headroom keeps
  // the rounding add from overflowing for any 32-bit input.
  function automatic logic [7:0] requant(input logic [ACC_W-1:0] acc,
                                         input logic [4:0]       sh,
                                         input logic             relu);
    logic signed [ACC_W:0] ext_v;
    logic signed [ACC_W:0] rnd_v;
    logic signed [ACC_W:0] shr_v;
    logic [7:0]            res_v;
    ext_v = $signed({acc[ACC_W-1], acc});
    if (sh != 5'd0) begin
      rnd_v = ext_v + $signed(RND_ONE << (sh - 5'd1));
    end else begin
      rnd_v = ext_v;
    end
    shr_v = rnd_v >>> sh;
    shr_v = (relu && shr_v[ACC_W]) ? '0 : shr_v;
    if (shr_v > SAT_MAX) begin
      res_v = 8'h7F;
    end else if (shr_v < SAT_MIN) begin
      res_v = 8'h80;
    end else begin
      res_v = shr_v[7:0];
    end
    return res_v;
  endfunction

  logic [4:0]       shift_q_r,   shift_nxt_s;
  logic             relu_q_r,    relu_nxt_s;
  logic [CNT_W-1:0] lane_cnt_r,  lane_cnt_nxt_s;
  logic [OUT_W-1:0] lane_buf_r,  lane_buf_nxt_s;
  logic [OUT_W-1:0] out_data_r,  out_data_nxt_s;
  logic             out_valid_r, out_valid_nxt_s;
  logic             last_q_r,    last_nxt_s;
  logic [31:0]      words_r,     words_nxt_s;
  logic             busy_r,      busy_nxt_s;
  logic             done_r,      done_nxt_s;

  logic             acc_ready_s;
  logic             accept_s;
  logic             out_hs_s;
  logic             word_end_s;
  logic [7:0]       byte_s;
  logic [OUT_W-1:0] merged_s;

  // Handshake qualifiers and the buffer with the incoming byte merged in.
  // Unwritten upper lanes are already zero because the buffer is cleared
  // whenever a word is emitted.
  always_comb begin
    acc_ready_s = !out_valid_r || bus.out_ready;
    accept_s    = bus.acc_valid && acc_ready_s;
    out_hs_s    = out_valid_r && bus.out_ready;
    word_end_s  = bus.acc_last || (lane_cnt_r == LAST_LANE);
    byte_s      = requant(bus.acc_data, shift_q_r, relu_q_r);
    merged_s    = lane_buf_r;
    merged_s[{lane_cnt_r, 3'b000} +: 8] = byte_s;
  end

  // Next-state logic: start dominates; otherwise retire the output word and
  // absorb an accepted beat (both may happen in one cycle for zero bubbles).
  always_comb begin
    shift_nxt_s     = shift_q_r;
    relu_nxt_s      = relu_q_r;
    lane_cnt_nxt_s  = lane_cnt_r;
    lane_buf_nxt_s  = lane_buf_r;
    out_data_nxt_s  = out_data_r;
    out_valid_nxt_s = out_valid_r;
    last_nxt_s      = last_q_r;
    words_nxt_s     = words_r;
    busy_nxt_s      = busy_r;
    done_nxt_s      = 1'b0;
    if (start) begin
      shift_nxt_s     = cfg_shift;
      relu_nxt_s      = cfg_relu;
      lane_cnt_nxt_s  = '0;
      lane_buf_nxt_s  = '0;
      out_valid_nxt_s = 1'b0;
      last_nxt_s      = 1'b0;
      words_nxt_s     = 32'd0;
      busy_nxt_s      = 1'b1;
    end else begin
      if (out_hs_s) begin
        words_nxt_s     = words_r + 32'd1;
        out_valid_nxt_s = 1'b0;
        if (last_q_r) begin
          done_nxt_s = 1'b1;
          busy_nxt_s = 1'b0;
        end else begin
          done_nxt_s = 1'b0;
          busy_nxt_s = busy_r;
        end
      end else begin
        words_nxt_s = words_r;
      end
      if (accept_s) begin
        if (word_end_s) begin
          out_data_nxt_s  = merged_s;
          out_valid_nxt_s = 1'b1;
          last_nxt_s      = bus.acc_last;
          lane_cnt_nxt_s  = '0;
          lane_buf_nxt_s  = '0;
        end else begin
          lane_buf_nxt_s  = merged_s;
          lane_cnt_nxt_s  = lane_cnt_r + CNT_ONE;
        end
      end else begin
        lane_buf_nxt_s = lane_buf_r;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q_r   <= 5'd0;
      relu_q_r    <= 1'b0;
      lane_cnt_r  <= '0;
      lane_buf_r  <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      last_q_r    <= 1'b0;
      words_r     <= 32'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      shift_q_r   <= shift_nxt_s;
      relu_q_r    <= relu_nxt_s;
      lane_cnt_r  <= lane_cnt_nxt_s;
      lane_buf_r  <= lane_buf_nxt_s;
      out_data_r  <= out_data_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      last_q_r    <= last_nxt_s;
      words_r     <= words_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
    end
  end

  assign bus.acc_ready = acc_ready_s;
  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign out_words     = words_r;
  assign busy          = busy_r;
  assign done          = done_r;

endmodule
